instruction_loader: RTL and testbench
=====================================

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 32: instruction word width.
REQ-002 The block SHALL have parameter NB_BYTE, default 8: received byte width (NB_DATA = 4*NB_BYTE).
REQ-003 The block SHALL have parameter NB_ADDR, default 8: instruction memory word-address width.
REQ-004 The block SHALL have parameter HALT_WORD, default 32'hFFFF_FFFF: end-of-program instruction.
REQ-005 The block SHALL have port i_clock, input, 1: single clock, all logic on its rising edge.
REQ-006 The block SHALL have port i_reset, input, 1: synchronous, active-high reset.
REQ-007 The block SHALL have port i_start, input, 1: single-cycle pulse beginning a program load.
REQ-008 The block SHALL have port i_byte, input, NB_BYTE: byte from the serial receiver.
REQ-009 The block SHALL have port i_byte_valid, input, 1: i_byte is valid this cycle (one-cycle pulse per byte).
REQ-010 The block SHALL have port o_wr_enable, output, 1: instruction memory write strobe.
REQ-011 The block SHALL have port o_wr_addr, output, NB_ADDR: instruction memory word address.
REQ-012 The block SHALL have port o_wr_data, output, NB_DATA: instruction word to write.
REQ-013 The block SHALL have port o_busy, output, 1: load in progress; fetch stage is held.
REQ-014 The block SHALL have port o_load_done, output, 1: program fully loaded; level until next i_start.
REQ-015 The block SHALL have port o_error, output, 1: checksum mismatch (only driven when LOADER_CHECKSUM_EN is defined, else tied 0).

Function
REQ-016 The FSM SHALL have states IDLE, RECEIVE, WRITE, CHECK, DONE.
REQ-017 IDLE -> RECEIVE on i_start; word address and byte counter SHALL clear to 0; i_byte_valid in IDLE SHALL be ignored.
REQ-018 In RECEIVE each i_byte_valid SHALL shift i_byte into the word buffer, first byte received = bits [NB_DATA-1 : NB_DATA-NB_BYTE] (big-endian).
REQ-019 On the 4th accepted byte the FSM SHALL go to WRITE; o_wr_enable SHALL be high exactly one cycle, the cycle after the 4th byte, with o_wr_data = assembled word and o_wr_addr = current word address.
REQ-020 After WRITE the address SHALL increment by 1 and the FSM SHALL return to RECEIVE, unless the written word equals HALT_WORD or the address was 2^NB_ADDR-1 (memory full), in which case it SHALL go to CHECK.
REQ-021 The HALT_WORD itself SHALL be written to memory; address SHALL NOT wrap past 2^NB_ADDR-1.
REQ-022 Without LOADER_CHECKSUM_EN, CHECK SHALL pass to DONE in one cycle.
REQ-023 In DONE o_load_done SHALL be 1 and o_busy 0; i_byte_valid SHALL be ignored; i_start SHALL restart a load (-> RECEIVE, o_load_done clears).
REQ-024 o_busy SHALL be 1 in RECEIVE, WRITE, CHECK; 0 in IDLE and DONE.
REQ-025 i_start while o_busy SHALL be ignored; i_byte_valid during WRITE SHALL be accepted as byte 0 of the next word.

Reset
REQ-026 On i_reset (any state, including mid-word) the FSM SHALL go to IDLE and o_wr_enable, o_wr_addr, o_wr_data, o_busy, o_load_done, o_error, byte counter and checksum SHALL all be 0; the partial word SHALL be discarded.
REQ-027 i_reset SHALL take priority over i_start and i_byte_valid in the same cycle.

Configuration
REQ-028 With macro LOADER_CHECKSUM_EN defined, the block SHALL keep a running XOR of all received program bytes; in CHECK it SHALL wait for one further byte and set o_error = 1 if it differs from the XOR, then go to DONE (o_load_done = 1 regardless); o_error SHALL clear on i_start.
REQ-029 Without LOADER_CHECKSUM_EN the checksum register and the CHECK wait SHALL not exist and o_error SHALL be constant 0.

Verification
REQ-030 i_start, bytes 20,01,00,05 then FF,FF,FF,FF -> writes addr 0 data 32'h2001_0005, addr 1 data 32'hFFFF_FFFF, each one cycle after 4th byte; o_load_done=1.
REQ-031 Reset after 2 bytes of a word, then i_start and 4 bytes 00,00,00,00 -> single write addr 0 data 0, no stale bytes.
REQ-032 NB_ADDR=2, 16 non-halt bytes -> writes addr 0..3, then DONE; 17th byte ignored, no 5th write.
REQ-033 i_byte_valid before i_start and after DONE -> no o_wr_enable; i_start mid-load -> no restart, address unchanged.
REQ-034 LOADER_CHECKSUM_EN: bytes 12,34,56,78,FF,FF,FF,FF then checksum 08 -> o_error=0; checksum 09 -> o_error=1, o_load_done=1.

Source files
------------

// File: rtl/instruction_loader.sv
// Assembles big-endian bytes into words and writes them to instruction memory; write strobe one cycle after the 4th byte, no backpressure.
// Optional trailing XOR checksum byte with error flag under macro LOADER_CHECKSUM_EN.
module instruction_loader #(
    parameter int                 NB_DATA   = 32,
    parameter int                 NB_BYTE   = 8,
    parameter int                 NB_ADDR   = 8,
    parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_BYTE-1:0] i_byte,
    input  logic               i_byte_valid,
    output logic               o_wr_enable,
    output logic [NB_ADDR-1:0] o_wr_addr,
    output logic [NB_DATA-1:0] o_wr_data,
    output logic               o_busy,
    output logic               o_load_done,
    output logic               o_error
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECEIVE,
        ST_WRITE,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [NB_DATA-1:0] r_word;
    logic [1:0]         r_byte_cnt;
    logic [NB_ADDR-1:0] r_addr;
    logic               w_last;
    logic               w_accept;
    logic               w_start;

    // The current word ends the program if it is the halt word or fills the last address.
    assign w_last   = (r_word == HALT_WORD) || (r_addr == {NB_ADDR{1'b1}});
    assign w_start  = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_accept = i_byte_valid &&
                      ((r_state == ST_RECEIVE) || ((r_state == ST_WRITE) && !w_last));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (i_start) w_next_state = ST_RECEIVE;
            ST_RECEIVE: if (i_byte_valid && (r_byte_cnt == 2'd3)) w_next_state = ST_WRITE;
            ST_WRITE:   w_next_state = w_last ? ST_CHECK : ST_RECEIVE;
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK:   if (i_byte_valid) w_next_state = ST_DONE;
`else
            ST_CHECK:   w_next_state = ST_DONE;
`endif
            ST_DONE:    if (i_start) w_next_state = ST_RECEIVE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_word     <= '0;
            r_byte_cnt <= '0;
            r_addr     <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_start) begin
                r_word     <= '0;
                r_byte_cnt <= '0;
                r_addr     <= '0;
            end else begin
                if (w_accept) begin
                    r_word     <= {r_word[NB_DATA-NB_BYTE-1:0], i_byte};
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                end
                if ((r_state == ST_WRITE) && !w_last)
                    r_addr <= r_addr + NB_ADDR'(1);
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [NB_BYTE-1:0] r_csum;
    logic               r_error;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_csum  <= '0;
            r_error <= 1'b0;
        end else if (w_start) begin
            r_csum  <= '0;
            r_error <= 1'b0;
        end else begin
            if (w_accept)
                r_csum <= r_csum ^ i_byte;
            if ((r_state == ST_CHECK) && i_byte_valid)
                r_error <= (i_byte != r_csum);
        end
    end

    assign o_error = r_error;
`else
    assign o_error = 1'b0;
`endif

    assign o_wr_enable = (r_state == ST_WRITE);
    assign o_wr_addr   = r_addr;
    assign o_wr_data   = (r_state == ST_WRITE) ? r_word : '0;
    assign o_busy      = (r_state == ST_RECEIVE) || (r_state == ST_WRITE) || (r_state == ST_CHECK);
    assign o_load_done = (r_state == ST_DONE);

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: a default instance plus a 4-word (NB_ADDR=2) instance sharing stimulus.
module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [7:0]  i_byte;
    logic        i_byte_valid;

    logic        wr_en,   busy,   done,   err;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        s_wr_en, s_busy, s_done, s_err;
    logic [1:0]  s_wr_addr;
    logic [31:0] s_wr_data;

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt   = 0;
    int s_wr_cnt = 0;
    int snap;

    always #5 clk = ~clk;

    instruction_loader dut (
        .i_clock(clk), .i_reset(i_reset), .i_start(i_start),
        .i_byte(i_byte), .i_byte_valid(i_byte_valid),
        .o_wr_enable(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
        .o_busy(busy), .o_load_done(done), .o_error(err)
    );

    instruction_loader #(.NB_ADDR(2)) dut_small (
        .i_clock(clk), .i_reset(i_reset), .i_start(i_start),
        .i_byte(i_byte), .i_byte_valid(i_byte_valid),
        .o_wr_enable(s_wr_en), .o_wr_addr(s_wr_addr), .o_wr_data(s_wr_data),
        .o_busy(s_busy), .o_load_done(s_done), .o_error(s_err)
    );

    always @(negedge clk) begin
        if (wr_en)   wr_cnt++;
        if (s_wr_en) s_wr_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // All stimulus tasks are entered and left on a falling edge.
    task automatic send_byte(input logic [7:0] b);
        i_byte       = b;
        i_byte_valid = 1'b1;
        @(negedge clk);
        i_byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic pulse_reset();
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b1; i_start = 1'b0; i_byte = '0; i_byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        i_reset = 1'b0;

        check_val("rst_wr_en",   wr_en,   0);
        check_val("rst_wr_addr", wr_addr, 0);
        check_val("rst_wr_data", wr_data, 0);
        check_val("rst_busy",    busy,    0);
        check_val("rst_done",    done,    0);
        check_val("rst_error",   err,     0);

        // Bytes before any start are ignored.
        send_word(32'hAABB_CCDD);
        idle(2);
        check_val("idle_no_write", wr_cnt, 0);
        check_val("idle_busy",     busy,   0);

        // Two-word program ending in the halt word; halt bytes follow back-to-back.
        pulse_start();
        check_val("start_busy", busy, 1);
        send_word(32'h2001_0005);
        check_val("w0_en",   wr_en,   1);
        check_val("w0_addr", wr_addr, 0);
        check_val("w0_data", wr_data, 32'h2001_0005);
        send_word(32'hFFFF_FFFF);
        check_val("w1_en",   wr_en,   1);
        check_val("w1_addr", wr_addr, 1);
        check_val("w1_data", wr_data, 32'hFFFF_FFFF);
        idle(1);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h24);
`endif
        idle(2);
        check_val("prog_done",   done,   1);
        check_val("prog_busy",   busy,   0);
        check_val("prog_error",  err,    0);
        check_val("prog_writes", wr_cnt, 2);

        // Bytes in DONE are ignored.
        send_word(32'h1122_3344);
        idle(2);
        check_val("done_no_write", wr_cnt, 2);
        check_val("done_held",     done,   1);

        // Restart from DONE, then a start mid-word must not restart the load.
        pulse_start();
        check_val("restart_done_clr", done, 0);
        send_word(32'h0102_0304);
        check_val("rs_w0_addr", wr_addr, 0);
        check_val("rs_w0_data", wr_data, 32'h0102_0304);
        send_byte(8'h05);
        send_byte(8'h06);
        pulse_start();
        send_byte(8'h07);
        send_byte(8'h08);
        check_val("midstart_en",   wr_en,   1);
        check_val("midstart_addr", wr_addr, 1);
        check_val("midstart_data", wr_data, 32'h0506_0708);

        // Reset mid-word discards the partial word.
        pulse_reset();
        pulse_start();
        send_byte(8'hAB);
        send_byte(8'hCD);
        pulse_reset();
        check_val("midrst_busy", busy,    0);
        check_val("midrst_addr", wr_addr, 0);
        snap = wr_cnt;
        pulse_start();
        send_word(32'h0000_0000);
        check_val("clean_en",   wr_en,   1);
        check_val("clean_addr", wr_addr, 0);
        check_val("clean_data", wr_data, 0);
        idle(2);
        check_val("clean_writes", wr_cnt - snap, 1);

        // Reset wins over a simultaneous start.
        i_reset = 1'b1; i_start = 1'b1;
        @(negedge clk);
        i_reset = 1'b0; i_start = 1'b0;
        idle(1);
        check_val("rst_prio_busy", busy, 0);

        // Memory-full stop on the 4-word instance.
        snap = s_wr_cnt;
        pulse_start();
        for (int w = 0; w < 4; w++) begin
            for (int b = 0; b < 4; b++) send_byte(8'(w*4 + b));
            check_val("full_en",   s_wr_en,   1);
            check_val("full_addr", s_wr_addr, w);
            check_val("full_data", s_wr_data,
                      {8'(w*4), 8'(w*4+1), 8'(w*4+2), 8'(w*4+3)});
        end
        idle(1);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        idle(2);
        check_val("full_done", s_done, 1);
        send_byte(8'h10);
        idle(3);
        check_val("full_writes", s_wr_cnt - snap, 4);
        check_val("full_nowrap", s_wr_addr, 3);

`ifdef LOADER_CHECKSUM_EN
        pulse_reset();
        pulse_start();
        send_word(32'h1234_5678);
        send_word(32'hFFFF_FFFF);
        idle(1);
        send_byte(8'h08);
        idle(2);
        check_val("cs_good_err",  err,  0);
        check_val("cs_good_done", done, 1);
        pulse_start();
        send_word(32'h1234_5678);
        send_word(32'hFFFF_FFFF);
        idle(1);
        send_byte(8'h09);
        idle(2);
        check_val("cs_bad_err",  err,  1);
        check_val("cs_bad_done", done, 1);
        pulse_start();
        check_val("cs_err_clr", err, 0);
`else
        check_val("no_cs_err", err, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
